// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory answering the core's byte/word read/write strobes.
// Latency: accept edge + WAIT_CYCLES+1 edges to done; busy holds off new commands until IDLE.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_b,
  input  logic              mem_read_w,
  input  logic              mem_write_b,
  input  logic              mem_write_w,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int          DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TWO   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_THREE = ADDR_W'(3);

  // Command strobes are kept one-hot as {read_b, read_w, write_b, write_w}.
  localparam int C_RB = 3;
  localparam int C_RW = 2;
  localparam int C_WB = 1;
  localparam int C_WW = 0;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [3:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [7:0]        mem [DEPTH];

  logic [3:0]        strb_d;
  logic              any_d;
  logic              multi_d;
  logic              misalign_d;
  logic              illegal_d;
  logic              access_d;
  logic [ADDR_W-1:0] a1_d;
  logic [ADDR_W-1:0] a2_d;
  logic [ADDR_W-1:0] a3_d;
  logic [31:0]       rd_word_d;
  logic [31:0]       rd_byte_d;

  always_comb begin
    strb_d     = {mem_read_b, mem_read_w, mem_write_b, mem_write_w};
    any_d      = |strb_d;
    // More than one bit set iff clearing the lowest set bit leaves something.
    multi_d    = (strb_d & (strb_d - 4'd1)) != 4'd0;
    misalign_d = (mem_read_w | mem_write_w) && (addr[1:0] != 2'b00);
    illegal_d  = multi_d || misalign_d;
  end

  always_comb begin
    access_d  = (state_q == S_WAIT) && (cnt_q == 4'd0);
    a1_d      = addr_q + A_ONE;
    a2_d      = addr_q + A_TWO;
    a3_d      = addr_q + A_THREE;
    rd_word_d = {mem[a3_d], mem[a2_d], mem[a1_d], mem[addr_q]};
    rd_byte_d = {24'b0, mem[addr_q]};
  end

  // The array has no reset so its contents survive rst_n; an abort in WAIT
  // drops state_q to IDLE asynchronously, which suppresses the write below.
  always_ff @(posedge clk) begin
    if (access_d) begin
      if (cmd_q[C_WB]) begin
        mem[addr_q] <= wdata_q[7:0];
      end
      if (cmd_q[C_WW]) begin
        mem[addr_q] <= wdata_q[7:0];
        mem[a1_d]   <= wdata_q[15:8];
        mem[a2_d]   <= wdata_q[23:16];
        mem[a3_d]   <= wdata_q[31:24];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      cmd_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_d) begin
            if (illegal_d) begin
              state_q <= S_DONE;
              busy_q  <= 1'b1;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_INIT;
              cmd_q   <= strb_d;
              addr_q  <= addr;
              wdata_q <= wdata;
              busy_q  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            if (cmd_q[C_RB]) begin
              rdata_q <= rd_byte_d;
            end else if (cmd_q[C_RW]) begin
              rdata_q <= rd_word_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
